// File: rtl/pid_pkg.sv
// Shared types, widths and helpers for the PID speed controller.
// The sequencer state is exported so it can be observed from outside the core.
package pid_pkg;

  localparam int ACC_W = 36;
  localparam int ERR_W = 17;
  localparam int DER_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ERR   = 3'd1,
    ST_MUL_P = 3'd2,
    ST_MUL_I = 3'd3,
    ST_MUL_D = 3'd4,
    ST_OUT   = 3'd5
  } pid_state_e;

  typedef enum logic [1:0] {
    MAC_SEL_P = 2'd0,
    MAC_SEL_I = 2'd1,
    MAC_SEL_D = 2'd2
  } mac_sel_e;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Shared multiply-accumulate: one signed 9 x I_W multiplier feeding a 36-bit
// accumulator. The sequencer picks the gain/operand pair and load or add.
module pid_mac
  import pid_pkg::*;
#(
  parameter int I_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       sel_i,
  input  logic             load_i,
  input  logic             add_i,
  input  logic [7:0]       kp_i,
  input  logic [7:0]       ki_i,
  input  logic [6:0]       kd_i,
  input  logic [ERR_W-1:0] err_i,
  input  logic [I_W-1:0]   integ_i,
  input  logic [DER_W-1:0] deriv_i,
  output logic [ACC_W-1:0] acc_next_o
);

  logic signed [8:0]       gain_s;
  logic signed [I_W-1:0]   op_s;
  logic signed [I_W+8:0]   prod_s;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  // Gains are unsigned, so they enter the signed multiplier with a zero MSB.
  always_comb begin
    gain_s = '0;
    op_s   = '0;
    case (sel_i)
      MAC_SEL_P: begin
        gain_s = signed'({1'b0, kp_i});
        op_s   = signed'({{(I_W - ERR_W){err_i[ERR_W-1]}}, err_i});
      end
      MAC_SEL_I: begin
        gain_s = signed'({1'b0, ki_i});
        op_s   = signed'(integ_i);
      end
      MAC_SEL_D: begin
        gain_s = signed'({2'b00, kd_i});
        op_s   = signed'({{(I_W - DER_W){deriv_i[DER_W-1]}}, deriv_i});
      end
      default: ;
    endcase
  end

  always_comb begin
    prod_s   = (I_W + 9)'(gain_s) * (I_W + 9)'(op_s);
    prod_ext = ACC_W'(prod_s);
    acc_d    = acc_q;
    if (load_i) begin
      acc_d = prod_ext;
    end else if (add_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/pid_controller.sv
// PID speed loop: turns commutation period error into a PWM duty command using
// a 6-cycle shared-MAC schedule; drives a fixed open-loop duty until tuned.
module pid_controller
  import pid_pkg::*;
#(
  parameter int                DATA_WIDTH     = 16,
  parameter int                DUTY_W         = 8,
  parameter int                SHIFT          = 8,
  parameter int                I_W            = 24,
  parameter logic [DUTY_W-1:0] OPEN_LOOP_DUTY = 8'd64
) (
  input  logic                  clk_div,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  tuning_done,
  input  logic [7:0]            Kp,
  input  logic [7:0]            Ki,
  input  logic [6:0]            Kd,
  input  logic [DATA_WIDTH-1:0] period_speed,
  input  logic [DATA_WIDTH-1:0] setpoint_period,
  output logic [DUTY_W-1:0]     duty,
  output logic                  duty_valid,
  output logic                  overrun,
  output logic [2:0]            dbg_state_o
);

  // duty_valid is a one-cycle qualifier for duty; there is no backpressure,
  // so the consumer must capture duty in the cycle duty_valid is high.

  localparam logic signed [ACC_W-1:0] DUTY_MAX = ACC_W'(2 ** DUTY_W - 1);

  pid_state_e state_q, state_d;

  logic                    td_q;
  logic [7:0]              kp_q;
  logic [7:0]              ki_q;
  logic [6:0]              kd_q;
  logic [DATA_WIDTH-1:0]   per_q;
  logic [DATA_WIDTH-1:0]   sp_q;
  logic signed [ERR_W-1:0] e_w;
  logic signed [ERR_W-1:0] e_q;
  logic signed [ERR_W-1:0] e_prev_q;
  logic signed [DER_W-1:0] d_w;
  logic signed [DER_W-1:0] d_q;
  logic signed [I_W-1:0]   integ_q;
  logic signed [I_W-1:0]   integ_upd;
  logic signed [63:0]      integ_sum;
  logic signed [63:0]      integ_sat;
  logic                    first_q;
  logic                    clamp_hi_q;
  logic                    clamp_lo_q;
  logic                    clamp_hi_w;
  logic                    clamp_lo_w;
  logic [DUTY_W-1:0]       duty_q;
  logic [DUTY_W-1:0]       duty_w;
  logic                    duty_valid_q;
  logic                    overrun_q;
  logic                    rise;
  logic                    accept;
  logic                    hold;
  logic [1:0]              mac_sel;
  logic                    mac_load;
  logic                    mac_add;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] u_w;

  // A tick coinciding with the gain-latch edge is ignored: gains settle first.
  assign rise   = tuning_done & ~td_q;
  assign accept = (state_q == ST_IDLE) & sample_tick & tuning_done & ~rise;

  assign e_w = ERR_W'(signed'(per_q)) - ERR_W'(signed'(sp_q));
  assign d_w = DER_W'(e_w) - DER_W'(e_prev_q);

  // Anti-windup: stop integrating in the direction the output is already pinned.
  assign hold = (clamp_hi_q & ~e_w[ERR_W-1] & (e_w != '0)) |
                (clamp_lo_q &  e_w[ERR_W-1]);

  assign integ_sum = 64'(integ_q) + 64'(e_w);
  assign integ_sat = sat_signed(integ_sum, I_W);
  assign integ_upd = integ_sat[I_W-1:0];

  always_comb begin
    state_d  = state_q;
    mac_sel  = MAC_SEL_P;
    mac_load = 1'b0;
    mac_add  = 1'b0;
    if (!tuning_done) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept) state_d = ST_ERR;
        ST_ERR:   state_d = ST_MUL_P;
        ST_MUL_P: begin
          mac_sel  = MAC_SEL_P;
          mac_load = 1'b1;
          state_d  = ST_MUL_I;
        end
        ST_MUL_I: begin
          mac_sel = MAC_SEL_I;
          mac_add = 1'b1;
          state_d = ST_MUL_D;
        end
        ST_MUL_D: begin
          mac_sel = MAC_SEL_D;
          mac_add = 1'b1;
          state_d = ST_OUT;
        end
        ST_OUT:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  pid_mac #(
    .I_W(I_W)
  ) u_mac (
    .clk_i      (clk_div),
    .rst_i      (reset),
    .sel_i      (mac_sel),
    .load_i     (mac_load),
    .add_i      (mac_add),
    .kp_i       (kp_q),
    .ki_i       (ki_q),
    .kd_i       (kd_q),
    .err_i      (e_q),
    .integ_i    (integ_q),
    .deriv_i    (d_q),
    .acc_next_o (acc_next)
  );

  // Shift and clamp the final sum as it forms, so duty lands with the OUT state.
  always_comb begin
    u_w        = acc_next >>> SHIFT;
    duty_w     = u_w[DUTY_W-1:0];
    clamp_hi_w = 1'b0;
    clamp_lo_w = 1'b0;
    if (u_w[ACC_W-1]) begin
      duty_w     = '0;
      clamp_lo_w = 1'b1;
    end else if (u_w > DUTY_MAX) begin
      duty_w     = '1;
      clamp_hi_w = 1'b1;
    end
  end

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      td_q         <= 1'b0;
      kp_q         <= '0;
      ki_q         <= '0;
      kd_q         <= '0;
      per_q        <= '0;
      sp_q         <= '0;
      e_q          <= '0;
      e_prev_q     <= '0;
      d_q          <= '0;
      integ_q      <= '0;
      first_q      <= 1'b0;
      clamp_hi_q   <= 1'b0;
      clamp_lo_q   <= 1'b0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      td_q         <= tuning_done;
      duty_valid_q <= 1'b0;
      if (sample_tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;

      if (!tuning_done) begin
        duty_q  <= OPEN_LOOP_DUTY;
        integ_q <= '0;
      end else if (rise) begin
        // Fresh gains start from a clean integrator and no clamp history.
        kp_q       <= Kp;
        ki_q       <= Ki;
        kd_q       <= Kd;
        integ_q    <= '0;
        first_q    <= 1'b1;
        clamp_hi_q <= 1'b0;
        clamp_lo_q <= 1'b0;
      end else begin
        if (accept) begin
          per_q <= period_speed;
          sp_q  <= setpoint_period;
        end
        case (state_q)
          ST_ERR: begin
            e_q     <= e_w;
            d_q     <= first_q ? '0 : d_w;
            first_q <= 1'b0;
            if (!hold) integ_q <= integ_upd;
          end
          ST_MUL_D: begin
            duty_q       <= duty_w;
            duty_valid_q <= 1'b1;
            clamp_hi_q   <= clamp_hi_w;
            clamp_lo_q   <= clamp_lo_w;
          end
          ST_OUT:  e_prev_q <= e_q;
          default: ;
        endcase
      end
    end
  end

  assign duty        = duty_q;
  assign duty_valid  = duty_valid_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pid_controller.sv
// Directed bench for pid_controller: integer-level PID model feeds an expected
// queue that a per-cycle compare process checks against duty/duty_valid/overrun.
module tb_pid_controller;

  logic        clk_div = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        tuning_done;
  logic [7:0]  Kp;
  logic [7:0]  Ki;
  logic [6:0]  Kd;
  logic [15:0] period_speed;
  logic [15:0] setpoint_period;
  logic [7:0]  duty;
  logic        duty_valid;
  logic        overrun;
  logic [2:0]  dbg_state;

  localparam int BIG = 1 << 30;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit ol_exp   = 1'b0;

  logic [7:0] exp_q[$];
  int         due_q[$];

  int     m_kp, m_ki, m_kd;
  longint m_i;
  int     m_eprev;
  bit     m_first, m_chi, m_clo;
  int     busy_until  = 0;
  int     ovr_set_cyc = BIG;

  pid_controller dut (
    .clk_div         (clk_div),
    .reset           (reset),
    .sample_tick     (sample_tick),
    .tuning_done     (tuning_done),
    .Kp              (Kp),
    .Ki              (Ki),
    .Kd              (Kd),
    .period_speed    (period_speed),
    .setpoint_period (setpoint_period),
    .duty            (duty),
    .duty_valid      (duty_valid),
    .overrun         (overrun),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / cycle bookkeeping ----------------
  always #5 clk_div = ~clk_div;

  always @(posedge clk_div) begin
    cyc    <= cyc + 1;
    ol_exp <= !reset && !tuning_done;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain-integer PID: floor-divided sum, clamp to 0..255, integrator held
  // while pushing further into an active clamp.
  function automatic int model_sample(input int per, input int sp);
    int     e, d, r;
    longint acc, u;
    e = per - sp;
    d = m_first ? 0 : e - m_eprev;
    m_first = 1'b0;
    if (!((m_chi && e > 0) || (m_clo && e < 0))) begin
      m_i = m_i + e;
      if (m_i > 8388607)  m_i = 8388607;
      if (m_i < -8388608) m_i = -8388608;
    end
    acc = longint'(m_kp) * e + longint'(m_ki) * m_i + longint'(m_kd) * d;
    u = acc / 256;
    if (acc < 0 && (acc % 256) != 0) u = u - 1;
    m_chi = 1'b0;
    m_clo = 1'b0;
    if (u < 0) begin
      r = 0;
      m_clo = 1'b1;
    end else if (u > 255) begin
      r = 255;
      m_chi = 1'b1;
    end else begin
      r = int'(u);
    end
    m_eprev = e;
    return r;
  endfunction

  function automatic void model_abort();
    exp_q.delete();
    due_q.delete();
    busy_until = 0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk_div) begin
    if (!reset && cyc > 0) begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        check("duty_valid_due", duty_valid, 1);
        if (duty_valid) check("duty_value", duty, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        check("no_spurious_valid", duty_valid, 0);
      end
      if (ol_exp) check("open_loop_duty", duty, 64);
      check("overrun_flag", overrun, (cyc >= ovr_set_cyc));
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_div);
      #1;
    end
  endtask

  task automatic do_tick(input int per, input int sp, input int lit);
    int r;
    int c;
    c = cyc;
    period_speed    = per[15:0];
    setpoint_period = sp[15:0];
    sample_tick     = 1'b1;
    if (c < busy_until) begin
      if (ovr_set_cyc > c + 1) ovr_set_cyc = c + 1;
    end else if (tuning_done) begin
      busy_until = c + 6;
      r = model_sample(per, sp);
      exp_q.push_back(r[7:0]);
      due_q.push_back(c + 5);
      if (lit >= 0) check("model_literal", r, lit);
    end
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic run_sample(input int per, input int sp, input int lit);
    do_tick(per, sp, lit);
    step(5);
  endtask

  task automatic set_gains(input int kp, input int ki, input int kd, input bit tick_on_rise);
    if (tuning_done) begin
      tuning_done = 1'b0;
      model_abort();
      step(2);
    end
    Kp          = kp[7:0];
    Ki          = ki[7:0];
    Kd          = kd[6:0];
    tuning_done = 1'b1;
    sample_tick = tick_on_rise;
    m_kp = kp; m_ki = ki; m_kd = kd;
    m_i = 0; m_first = 1'b1; m_chi = 1'b0; m_clo = 1'b0;
    step(1);
    sample_tick = 1'b0;
    step(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; sample_tick = 1'b0; tuning_done = 1'b0;
    Kp = '0; Ki = '0; Kd = '0; period_speed = '0; setpoint_period = '0;
    m_kp = 0; m_ki = 0; m_kd = 0; m_i = 0; m_eprev = 0;
    m_first = 1'b0; m_chi = 1'b0; m_clo = 1'b0;
    repeat (2) @(posedge clk_div);
    #1;
    check("reset_duty", duty, 0);
    check("reset_valid", duty_valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_state", dbg_state, 0);
    reset = 1'b0;
    step(1);
    check("open_loop_first_edge", duty, 64);

    // Ticks before tuning completes are ignored.
    run_sample(1512, 1000, -1);
    run_sample(500, 1000, -1);

    // Proportional (tick on the latch edge is ignored).
    set_gains(4, 0, 0, 1'b1);
    run_sample(1512, 1000, 8);
    run_sample(1512, 1000, 8);

    // Clamp high / low.
    set_gains(255, 0, 0, 1'b0);
    run_sample(2000, 1000, 255);
    set_gains(4, 0, 0, 1'b0);
    run_sample(900, 1000, 0);

    // Integral, then saturation with anti-windup hold.
    set_gains(0, 1, 0, 1'b0);
    run_sample(1256, 1000, 1);
    run_sample(1256, 1000, 2);
    run_sample(1256, 1000, 3);
    check("integ_after_three", dut.integ_q, m_i);
    set_gains(0, 255, 0, 1'b0);
    run_sample(2000, 1000, 255);
    run_sample(2000, 1000, 255);
    check("integ_held_high", dut.integ_q, 1000);
    run_sample(0, 1000, 0);
    check("integ_released", dut.integ_q, 0);

    // Derivative: first sample after latch has d forced to zero.
    set_gains(0, 0, 16, 1'b0);
    run_sample(1000, 1000, 0);
    run_sample(1064, 1000, 4);
    run_sample(1064, 1000, 0);
    run_sample(1000, 1000, 0);

    // Mixed gains with low-clamp integrator hold.
    set_gains(3, 2, 5, 1'b0);
    run_sample(1300, 1000, 5);
    run_sample(1100, 1000, 0);
    run_sample(950, 1000, 0);
    run_sample(980, 1000, 3);
    check("integ_held_low", dut.integ_q, 350);

    // Overrun: ticks during ERR..OUT are dropped and set the sticky flag.
    set_gains(4, 0, 0, 1'b0);
    do_tick(1512, 1000, 8);
    step(1);
    do_tick(1512, 1000, -1);
    step(2);
    do_tick(1512, 1000, -1);
    step(4);
    check("overrun_sticky", overrun, 1);

    // tuning_done falling mid-sample aborts with no pulse.
    do_tick(1512, 1000, -1);
    tuning_done = 1'b0;
    model_abort();
    step(1);
    check("abort_open_loop", duty, 64);
    step(6);

    // Asynchronous reset while in MUL_I.
    set_gains(4, 0, 0, 1'b0);
    do_tick(1512, 1000, -1);
    step(2);
    check("state_mul_i", dbg_state, 3);
    #2;
    reset = 1'b1;
    tuning_done = 1'b0;
    model_abort();
    ovr_set_cyc = BIG;
    m_i = 0; m_eprev = 0; m_chi = 1'b0; m_clo = 1'b0;
    #1;
    check("async_reset_duty", duty, 0);
    check("async_reset_valid", duty_valid, 0);
    check("async_reset_overrun", overrun, 0);
    check("async_reset_integ", dut.integ_q, 0);
    step(2);
    reset = 1'b0;
    step(2);
    set_gains(4, 0, 0, 1'b0);
    run_sample(1512, 1000, 8);
    step(3);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
